fetch_stage: RTL and testbench

- Instruction-fetch stage and IF/ID pipeline register of the 16-bit core.
- Owns the PC: drives the instruction-memory address and registers the fetched instruction and its PC into IF/ID.
- Consumes the branch/jump resolution outputs (select, flush, target PC) from the downstream jump/branch decision logic.
- Handles stall, redirect squash and halt.

---
 rtl/fetch_stage.sv | 186 ++++++++++++++++++
 tb/tb_fetch_stage.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage -- instruction fetch and IF/ID pipeline register of the 16-bit core.
//
// The stage owns the program counter. It presents the PC on imem_addr, takes the
// word that the combinational instruction memory returns in the same cycle, and
// registers that word with its PC (and PC+2) into IF/ID. It also handles:
//   - stall from the hazard unit (PC and IF/ID hold),
//   - redirects from the jump/branch decision logic (select_jb / flush / target_pc),
//   - HALT, which freezes fetch until a redirect restarts it.
//
// Optional build macro: FETCH_PERF_CNT_EN
//   When defined, two saturating 16-bit performance counters are added:
//   perf_fetched (valid IF/ID loads) and perf_squashed (squash cycles).
//
// Ports:
//   clk           in   single clock, rising edge
//   rst_n         in   synchronous active-low reset
//   stall         in   hold PC and IF/ID
//   select_jb     in   jump/branch taken, load target_pc
//   flush         in   squash the instruction currently in IF/ID
//   target_pc     in   redirect address (bit 0 ignored)
//   imem_rdata    in   instruction word at imem_addr, same cycle
//   imem_addr     out  current PC register
//   ifid_instr    out  registered instruction
//   ifid_pc       out  registered PC of ifid_instr
//   ifid_pc_next  out  registered ifid_pc + 2
//   ifid_valid    out  IF/ID holds a real instruction
//   halted        out  fetch stopped on HALT
//   perf_fetched  out  (FETCH_PERF_CNT_EN only) valid IF/ID loads
//   perf_squashed out  (FETCH_PERF_CNT_EN only) squash cycles
module fetch_stage #(
  parameter int unsigned          PC_WIDTH    = 16,
  parameter logic [PC_WIDTH-1:0]  RESET_PC    = 16'h0000,
  parameter logic [15:0]          NOP_INSTR   = 16'h0800,
  parameter logic [4:0]           HALT_OPCODE = 5'b00000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                stall,
  input  logic                select_jb,
  input  logic                flush,
  input  logic [PC_WIDTH-1:0] target_pc,
  input  logic [15:0]         imem_rdata,
  output logic [PC_WIDTH-1:0] imem_addr,
  output logic [15:0]         ifid_instr,
  output logic [PC_WIDTH-1:0] ifid_pc,
  output logic [PC_WIDTH-1:0] ifid_pc_next,
  output logic                ifid_valid,
`ifdef FETCH_PERF_CNT_EN
  output logic [15:0]         perf_fetched,
  output logic [15:0]         perf_squashed,
`endif
  output logic                halted
);

  typedef enum logic [1:0] {
    ST_BOOT   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t              state_q;
  logic [PC_WIDTH-1:0] pc_q;
  logic [15:0]         ifid_instr_q;
  logic [PC_WIDTH-1:0] ifid_pc_q;
  logic [PC_WIDTH-1:0] ifid_pc_next_q;
  logic                ifid_valid_q;
  logic                halted_q;

  logic [PC_WIDTH-1:0] pc_plus2;
  logic [PC_WIDTH-1:0] target_aligned;
  logic                is_halt_word;
  logic                run_load;   // RUN cycle that loads a real instruction
  logic                squash;     // cycle in which a redirect/flush bubbles IF/ID

  // PC arithmetic wraps naturally at 2^PC_WIDTH.
  assign pc_plus2       = pc_q + PC_WIDTH'(2);
  // Instructions are halfword aligned; an odd target is rounded down.
  assign target_aligned = {target_pc[PC_WIDTH-1:1], 1'b0};
  assign is_halt_word   = (imem_rdata[15:11] == HALT_OPCODE);

  assign run_load = (state_q == ST_RUN) && !select_jb && !flush && !stall;
  // In HALTED only select_jb counts; flush alone changes nothing there.
  assign squash   = ((state_q == ST_RUN) && (select_jb || flush)) ||
                    ((state_q == ST_HALTED) && select_jb);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= ST_BOOT;
      pc_q           <= RESET_PC;
      ifid_instr_q   <= NOP_INSTR;
      ifid_pc_q      <= '0;
      ifid_pc_next_q <= '0;
      ifid_valid_q   <= 1'b0;
      halted_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_BOOT: begin
          // One settling cycle: the first word is fetched from RUN, so IF/ID
          // stays a bubble. A redirect arriving here is still honoured.
          ifid_instr_q <= NOP_INSTR;
          ifid_valid_q <= 1'b0;
          if (select_jb) begin
            pc_q <= target_aligned;
          end
          state_q <= ST_RUN;
        end

        ST_RUN: begin
          if (select_jb) begin
            // Redirect beats stall; the word fetched this cycle is dropped.
            pc_q         <= target_aligned;
            ifid_instr_q <= NOP_INSTR;
            ifid_valid_q <= 1'b0;
          end else if (flush) begin
            pc_q         <= pc_plus2;
            ifid_instr_q <= NOP_INSTR;
            ifid_valid_q <= 1'b0;
          end else if (!stall) begin
            ifid_instr_q   <= imem_rdata;
            ifid_pc_q      <= pc_q;
            ifid_pc_next_q <= pc_plus2;
            ifid_valid_q   <= 1'b1;
            if (is_halt_word) begin
              // HALT itself goes down the pipe; PC stays on it.
              state_q  <= ST_HALTED;
              halted_q <= 1'b1;
            end else begin
              pc_q <= pc_plus2;
            end
          end
        end

        ST_HALTED: begin
          ifid_instr_q <= NOP_INSTR;
          ifid_valid_q <= 1'b0;
          if (select_jb) begin
            pc_q     <= target_aligned;
            state_q  <= ST_RUN;
            halted_q <= 1'b0;
          end
        end

        default: begin
          state_q      <= ST_BOOT;
          ifid_instr_q <= NOP_INSTR;
          ifid_valid_q <= 1'b0;
          halted_q     <= 1'b0;
        end
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] perf_fetched_q;
  logic [15:0] perf_squashed_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_fetched_q  <= '0;
      perf_squashed_q <= '0;
    end else begin
      if (run_load && (perf_fetched_q != 16'hFFFF)) begin
        perf_fetched_q <= perf_fetched_q + 16'd1;
      end
      if (squash && (perf_squashed_q != 16'hFFFF)) begin
        perf_squashed_q <= perf_squashed_q + 16'd1;
      end
    end
  end

  assign perf_fetched  = perf_fetched_q;
  assign perf_squashed = perf_squashed_q;
`else
  // Without the counters these qualifiers have no consumer.
  logic unused_perf;
  assign unused_perf = run_load ^ squash;
`endif

  assign imem_addr    = pc_q;
  assign ifid_instr   = ifid_instr_q;
  assign ifid_pc      = ifid_pc_q;
  assign ifid_pc_next = ifid_pc_next_q;
  assign ifid_valid   = ifid_valid_q;
  assign halted       = halted_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed, self-checking bench for fetch_stage with an expected-result scoreboard.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        select_jb;
  logic        flush;
  logic [15:0] target_pc;
  logic [15:0] imem_rdata;
  logic [15:0] imem_addr;
  logic [15:0] ifid_instr;
  logic [15:0] ifid_pc;
  logic [15:0] ifid_pc_next;
  logic        ifid_valid;
  logic        halted;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] perf_fetched;
  logic [15:0] perf_squashed;
`endif

  int n_assert = 0;
  int n_fail   = 0;
  int exp_fetched  = 0;
  int exp_squashed = 0;

  logic        halt_en   = 1'b0;
  logic [15:0] halt_addr = 16'h0020;

  typedef struct {
    logic [15:0] pc;
    logic [15:0] instr;
    logic [15:0] pcn;
  } exp_t;
  exp_t sb[$];

  fetch_stage dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .select_jb    (select_jb),
    .flush        (flush),
    .target_pc    (target_pc),
    .imem_rdata   (imem_rdata),
    .imem_addr    (imem_addr),
    .ifid_instr   (ifid_instr),
    .ifid_pc      (ifid_pc),
    .ifid_pc_next (ifid_pc_next),
    .ifid_valid   (ifid_valid),
`ifdef FETCH_PERF_CNT_EN
    .perf_fetched (perf_fetched),
    .perf_squashed(perf_squashed),
`endif
    .halted       (halted)
  );

  always #5 clk = ~clk;

  // Program image: every word has a non-HALT opcode (top bits 11000).
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return {5'b11000, a[10:0] ^ 11'h2A5};
  endfunction

  always_comb begin
    if (halt_en && (imem_addr == halt_addr)) imem_rdata = 16'h0000;
    else                                     imem_rdata = mem_word(imem_addr);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ctl();
    stall = 1'b0; select_jb = 1'b0; flush = 1'b0; target_pc = 16'h0000;
  endtask

  // Normal fetch at pc: push expectation, clock, pop and compare against IF/ID.
  task automatic fetch(input logic [15:0] pc, input logic [15:0] word);
    exp_t e;
    chk("imem_addr_before_fetch", {16'h0, imem_addr}, {16'h0, pc});
    sb.push_back('{pc: pc, instr: word, pcn: pc + 16'd2});
    tick();
    exp_fetched++;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk("ifid_valid", {31'h0, ifid_valid}, 32'd1);
      chk("ifid_pc", {16'h0, ifid_pc}, {16'h0, e.pc});
      chk("ifid_instr", {16'h0, ifid_instr}, {16'h0, e.instr});
      chk("ifid_pc_next", {16'h0, ifid_pc_next}, {16'h0, e.pcn});
    end
  endtask

  // A cycle whose result must be a bubble in IF/ID with the given new PC.
  task automatic bubble(input string tag, input logic [15:0] new_pc);
    tick();
    chk({tag, "_valid"}, {31'h0, ifid_valid}, 32'd0);
    chk({tag, "_instr"}, {16'h0, ifid_instr}, 32'h0800);
    chk({tag, "_addr"}, {16'h0, imem_addr}, {16'h0, new_pc});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    clear_ctl();
    tick();
    tick();
    chk("rst_addr", {16'h0, imem_addr}, 32'h0000);
    chk("rst_instr", {16'h0, ifid_instr}, 32'h0800);
    chk("rst_valid", {31'h0, ifid_valid}, 32'd0);
    chk("rst_pc", {16'h0, ifid_pc}, 32'h0000);
    chk("rst_pc_next", {16'h0, ifid_pc_next}, 32'h0000);
    chk("rst_halted", {31'h0, halted}, 32'd0);

    // BOOT cycle: no fetch, PC holds
    rst_n = 1'b1;
    tick();
    chk("boot_valid", {31'h0, ifid_valid}, 32'd0);
    chk("boot_addr", {16'h0, imem_addr}, 32'h0000);
    $display("boot done: addr=%h valid=%b", imem_addr, ifid_valid);

    // Straight-line code
    for (int i = 0; i < 3; i++) begin
      fetch(16'(2 * i), mem_word(16'(2 * i)));
      $display("fetch: ifid_pc=%h instr=%h", ifid_pc, ifid_instr);
    end

    // Stall three cycles at PC 0x0006
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_addr", {16'h0, imem_addr}, 32'h0006);
      chk("stall_ifid_pc", {16'h0, ifid_pc}, 32'h0004);
      chk("stall_ifid_instr", {16'h0, ifid_instr}, {16'h0, mem_word(16'h0004)});
      chk("stall_valid", {31'h0, ifid_valid}, 32'd1);
      $display("stall cycle %0d: addr=%h ifid_pc=%h", i, imem_addr, ifid_pc);
    end
    stall = 1'b0;
    fetch(16'h0006, mem_word(16'h0006));
    fetch(16'h0008, mem_word(16'h0008));

    // Taken branch with flush at 0x000A
    chk("pre_redirect_addr", {16'h0, imem_addr}, 32'h000A);
    select_jb = 1'b1; flush = 1'b1; target_pc = 16'h0040;
    bubble("redirect", 16'h0040);
    exp_squashed++;
    clear_ctl();
    $display("redirect: addr=%h valid=%b", imem_addr, ifid_valid);
    fetch(16'h0040, mem_word(16'h0040));

    // Redirect beats stall; odd target rounded down
    stall = 1'b1; select_jb = 1'b1; target_pc = 16'h0101;
    bubble("redir_stall", 16'h0100);
    exp_squashed++;
    clear_ctl();
    $display("redirect over stall: addr=%h", imem_addr);
    fetch(16'h0100, mem_word(16'h0100));

    // Flush alone: bubble, PC still advances
    flush = 1'b1;
    bubble("flush_only", 16'h0104);
    exp_squashed++;
    clear_ctl();
    $display("flush only: addr=%h", imem_addr);
    fetch(16'h0104, mem_word(16'h0104));

    // HALT at 0x0020
    select_jb = 1'b1; target_pc = 16'h0020;
    bubble("to_halt", 16'h0020);
    exp_squashed++;
    clear_ctl();
    halt_en = 1'b1;
    fetch(16'h0020, 16'h0000);
    chk("halt_addr_frozen", {16'h0, imem_addr}, 32'h0020);
    chk("halt_flag", {31'h0, halted}, 32'd1);
    $display("halt: ifid_pc=%h halted=%b", ifid_pc, halted);
    bubble("halted_idle", 16'h0020);
    chk("halted_still", {31'h0, halted}, 32'd1);
    flush = 1'b1;
    bubble("halted_flush", 16'h0020);
    chk("halted_flush_flag", {31'h0, halted}, 32'd1);
    clear_ctl();
    select_jb = 1'b1; target_pc = 16'h0030;
    bubble("halt_exit", 16'h0030);
    exp_squashed++;
    chk("halt_exit_flag", {31'h0, halted}, 32'd0);
    clear_ctl();
    $display("halt exit: addr=%h halted=%b", imem_addr, halted);
    fetch(16'h0030, mem_word(16'h0030));
    fetch(16'h0032, mem_word(16'h0032));

    // PC wrap at 0xFFFE
    select_jb = 1'b1; target_pc = 16'hFFFE;
    bubble("to_wrap", 16'hFFFE);
    exp_squashed++;
    clear_ctl();
    fetch(16'hFFFE, mem_word(16'hFFFE));
    $display("wrap: ifid_pc_next=%h addr=%h", ifid_pc_next, imem_addr);
    fetch(16'h0000, mem_word(16'h0000));

    // Halt again, then reset while halted
    select_jb = 1'b1; target_pc = 16'h0020;
    bubble("to_halt2", 16'h0020);
    exp_squashed++;
    clear_ctl();
    fetch(16'h0020, 16'h0000);
    chk("halt2_flag", {31'h0, halted}, 32'd1);
`ifdef FETCH_PERF_CNT_EN
    chk("perf_fetched", {16'h0, perf_fetched}, 32'(exp_fetched));
    chk("perf_squashed", {16'h0, perf_squashed}, 32'(exp_squashed));
`endif
    rst_n = 1'b0;
    select_jb = 1'b1; target_pc = 16'h0066;
    tick();
    clear_ctl();
    exp_fetched = 0;
    exp_squashed = 0;
    chk("halt_rst_addr", {16'h0, imem_addr}, 32'h0000);
    chk("halt_rst_flag", {31'h0, halted}, 32'd0);
    chk("halt_rst_valid", {31'h0, ifid_valid}, 32'd0);
    $display("reset while halted: addr=%h halted=%b", imem_addr, halted);

    // Redirect during BOOT is honoured
    rst_n = 1'b1;
    select_jb = 1'b1; target_pc = 16'h0050;
    bubble("boot_redirect", 16'h0050);
    clear_ctl();
    $display("boot redirect: addr=%h", imem_addr);
    fetch(16'h0050, mem_word(16'h0050));
`ifdef FETCH_PERF_CNT_EN
    chk("perf_fetched_post_rst", {16'h0, perf_fetched}, 32'(exp_fetched));
    chk("perf_squashed_post_rst", {16'h0, perf_squashed}, 32'(exp_squashed));
`endif
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
